// File: rtl/match_evt_pkg.sv
// Shared types and sizing helpers for the match event counter.
// Imported by the stability filter and the counter top.
package match_evt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACTIVE
    } match_state_t;

    localparam int unsigned MIN_STAB_W = 1;

    // The stability counter only ever holds 0 .. STABLE_CYCLES-1.
    function automatic int unsigned stab_cnt_width(input int unsigned n);
        return (n <= 1) ? MIN_STAB_W : $clog2(n);
    endfunction

endpackage

// File: rtl/stability_filter.sv
// Qualifies the match flag: emits a one-cycle pulse on the sample that completes
// STABLE_CYCLES consecutive high samples, then waits for the flag to drop.
module stability_filter
    import match_evt_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_match,
    output logic o_evt_pulse
);

    localparam int unsigned SCW = stab_cnt_width(STABLE_CYCLES);
    localparam logic [SCW-1:0] LAST_CNT = SCW'(STABLE_CYCLES - 1);

    match_state_t   r_state;
    match_state_t   w_state_d;
    logic [SCW-1:0] r_stab_cnt;
    logic [SCW-1:0] w_stab_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_stab_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_stab_cnt <= w_stab_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_stab_cnt_d = r_stab_cnt;
        o_evt_pulse  = 1'b0;
        // Clear and disable both discard partial qualification and suppress the event.
        if (i_clear || !i_en) begin
            w_state_d    = IDLE;
            w_stab_cnt_d = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_match) begin
                        if (STABLE_CYCLES == 1) begin
                            w_state_d    = ACTIVE;
                            w_stab_cnt_d = '0;
                            o_evt_pulse  = 1'b1;
                        end else begin
                            w_state_d    = QUAL;
                            w_stab_cnt_d = SCW'(1);
                        end
                    end
                end
                QUAL: begin
                    if (!i_match) begin
                        w_state_d    = IDLE;
                        w_stab_cnt_d = '0;
                    end else if (r_stab_cnt == LAST_CNT) begin
                        w_state_d    = ACTIVE;
                        w_stab_cnt_d = '0;
                        o_evt_pulse  = 1'b1;
                    end else begin
                        w_stab_cnt_d = r_stab_cnt + SCW'(1);
                    end
                end
                ACTIVE: begin
                    if (!i_match) begin
                        w_state_d    = IDLE;
                        w_stab_cnt_d = '0;
                    end
                end
                default: begin
                    w_state_d    = IDLE;
                    w_stab_cnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/match_event_counter.sv
// Counts qualified match events in a saturating counter, publishes each on a
// valid/ready channel with a sticky drop flag, and pulses irq at THRESH.
module match_event_counter
    import match_evt_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned THRESH        = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_match_in,
    input  logic             i_evt_ready,
    output logic             o_evt_valid,
    output logic [CNT_W-1:0] o_evt_count,
    output logic [CNT_W-1:0] o_total_count,
    output logic             o_evt_drop,
    output logic             o_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_VAL = CNT_W'(THRESH);

    logic             w_evt;
    logic             w_sat;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;

    logic             r_evt_valid;
    logic [CNT_W-1:0] r_evt_count;
    logic [CNT_W-1:0] r_total_count;
    logic             r_evt_drop;
    logic             r_irq;

    stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stability_filter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_clear),
        .i_en        (i_en),
        .i_match     (i_match_in),
        .o_evt_pulse (w_evt)
    );

    assign w_sat      = (r_total_count == CNT_MAX);
    assign w_cnt_next = w_sat ? r_total_count : r_total_count + CNT_W'(1);
    assign w_accept   = r_evt_valid & i_evt_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_total_count <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_count   <= '0;
            r_evt_drop    <= 1'b0;
            r_irq         <= 1'b0;
        end else if (i_clear) begin
            r_total_count <= '0;
            r_evt_valid   <= 1'b0;
            r_evt_drop    <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (w_evt) begin
                r_total_count <= w_cnt_next;
                // Counter only moves upward, so THRESH is reached by an increment once.
                if (!w_sat && (w_cnt_next == THRESH_VAL)) begin
                    r_irq <= 1'b1;
                end
                if (!r_evt_valid || w_accept) begin
                    r_evt_valid <= 1'b1;
                    r_evt_count <= w_cnt_next;
                end else begin
                    r_evt_drop <= 1'b1;
                end
            end else if (w_accept) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign o_evt_valid   = r_evt_valid;
    assign o_evt_count   = r_evt_count;
    assign o_total_count = r_total_count;
    assign o_evt_drop    = r_evt_drop;
    assign o_irq         = r_irq;

endmodule

// File: tb/tb_match_event_counter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// run-length based reference model of the event counter.
module tb_match_event_counter;

    localparam int unsigned STABLE_CYCLES = 3;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned THRESH        = 4;
    localparam int          CNT_MAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clear;
    logic             match_in;
    logic             evt_ready;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_count;
    logic [CNT_W-1:0] total_count;
    logic             evt_drop;
    logic             irq;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_run   = 0;
    int m_total = 0;
    int m_cnt   = 0;
    bit m_valid = 1'b0;
    bit m_drop  = 1'b0;
    bit m_irq   = 1'b0;

    int irq_seen = 0;

    always #5 clk = ~clk;

    match_event_counter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W),
        .THRESH        (THRESH)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_clear       (clear),
        .i_match_in    (match_in),
        .i_evt_ready   (evt_ready),
        .o_evt_valid   (evt_valid),
        .o_evt_count   (evt_count),
        .o_total_count (total_count),
        .o_evt_drop    (evt_drop),
        .o_irq         (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // An event is the sample on which the enabled high run reaches exactly STABLE_CYCLES.
    task automatic model_update(input bit r, input bit c, input bit e, input bit m, input bit rd);
        bit evt;
        bit accept;
        if (r) begin
            m_run = 0; m_total = 0; m_cnt = 0;
            m_valid = 0; m_drop = 0; m_irq = 0;
        end else if (c) begin
            m_run = 0; m_total = 0;
            m_valid = 0; m_drop = 0; m_irq = 0;
        end else begin
            evt = 1'b0;
            if (e && m) begin
                if (m_run < 1000) m_run++;
                evt = (m_run == STABLE_CYCLES);
            end else begin
                m_run = 0;
            end
            accept = m_valid && rd;
            m_irq  = 1'b0;
            if (evt) begin
                if (m_total < CNT_MAX) begin
                    m_total++;
                    if (m_total == THRESH) m_irq = 1'b1;
                end
                if (!m_valid || accept) begin
                    m_valid = 1'b1;
                    m_cnt   = m_total;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (accept) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input bit r, input bit c, input bit e, input bit m, input bit rd);
        rst = r; clear = c; en = e; match_in = m; evt_ready = rd;
        @(posedge clk);
        #1;
        model_update(r, c, e, m, rd);
        if (irq) irq_seen++;
        check_eq("evt_valid", 32'(evt_valid), 32'(m_valid));
        check_eq("evt_count", 32'(evt_count), 32'(m_cnt));
        check_eq("total_count", 32'(total_count), 32'(m_total));
        check_eq("evt_drop", 32'(evt_drop), 32'(m_drop));
        check_eq("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic qual_event(input bit rd);
        for (int i = 0; i < STABLE_CYCLES; i++) step(0, 0, 1, 1, rd);
        step(0, 0, 1, 0, rd);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; en = 1'b0; match_in = 1'b0; evt_ready = 1'b0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1);
        check_eq("rst_total", 32'(total_count), 0);
        check_eq("rst_valid", 32'(evt_valid), 0);
        check_eq("rst_irq", 32'(irq), 0);

        // Short pulses never qualify
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 1, 1);
            step(0, 0, 1, 1, 1);
            step(0, 0, 1, 0, 1);
        end
        check_eq("t2_total", 32'(total_count), 0);

        // Single qualified event, visible one cycle after the third sample
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check_eq("t1_not_yet", 32'(evt_valid), 0);
        step(0, 0, 1, 1, 0);
        check_eq("t1_valid", 32'(evt_valid), 1);
        check_eq("t1_count", 32'(evt_count), 1);
        check_eq("t1_total", 32'(total_count), 1);
        step(0, 0, 1, 0, 0);

        // Two events with no consumer -> drop
        step(0, 1, 1, 0, 0);
        qual_event(0);
        qual_event(0);
        check_eq("t3_count", 32'(evt_count), 1);
        check_eq("t3_drop", 32'(evt_drop), 1);
        check_eq("t3_total", 32'(total_count), 2);

        // irq fires once at THRESH
        step(0, 1, 1, 0, 1);
        irq_seen = 0;
        for (int i = 0; i < 3; i++) qual_event(1);
        for (int i = 0; i < STABLE_CYCLES; i++) step(0, 0, 1, 1, 1);
        check_eq("t4_irq", 32'(irq), 1);
        check_eq("t4_total", 32'(total_count), THRESH);
        step(0, 0, 1, 0, 1);
        qual_event(1);
        check_eq("t4_irq_once", 32'(irq_seen), 1);

        // Saturation
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < CNT_MAX + 2; i++) qual_event(1);
        check_eq("t5_total", 32'(total_count), CNT_MAX);
        check_eq("t5_count", 32'(evt_count), CNT_MAX);

        // Clear on the qualifying cycle, then re-qualification from scratch
        step(0, 1, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1);
        check_eq("t6_total", 32'(total_count), 0);
        check_eq("t6_valid", 32'(evt_valid), 0);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        check_eq("t6_requal", 32'(total_count), 0);
        step(0, 0, 1, 1, 1);
        check_eq("t6_after", 32'(total_count), 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1);
        check_eq("t6_en_off", 32'(total_count), 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
